// File: rtl/smi_write_burst_ctrl_pkg.sv
// Shared definitions for the SMI write burst controller: FSM state encodings,
// the 4KB AXI boundary, the AXI length width and the burst sizing helper.
package smi_write_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        StReset,
        StIdle,
        StSetup,
        StAddr
    } burstState_t;

    localparam int unsigned Boundary4k  = 4096;
    localparam int unsigned AxiLenWidth = 8;

    // Beats in the next burst: limited by what is left, the max burst length and
    // the distance to the next 4KB boundary (addrLow is flit aligned).
    function automatic logic [16:0] calcBurst(
        input logic [11:0] addrLow,
        input logic [16:0] remaining,
        input int unsigned maxBurst,
        input int unsigned offW
    );
        logic [16:0] toBoundary;
        logic [16:0] burst;
        toBoundary = (17'(Boundary4k) - {5'd0, addrLow}) >> offW;
        burst = remaining;
        if (burst > 17'(maxBurst)) begin
            burst = 17'(maxBurst);
        end
        if (burst > toBoundary) begin
            burst = toBoundary;
        end
        return burst;
    endfunction

endpackage

// File: rtl/smi_burst_len_fifo.sv
// Burst-length FIFO: one entry per issued AW burst, holding {beats-1, lastOfFrame}.
// A push is accepted while full when a pop happens in the same cycle.
module smi_burst_len_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       push,
    input  logic [7:0] pushLen,
    input  logic       pushLast,
    input  logic       pop,
    output logic [7:0] popLen,
    output logic       popLast,
    output logic       full,
    output logic       almostFull,
    output logic       empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      lenMem  [Depth];
    logic            lastMem [Depth];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] count;
    logic            doPush;
    logic            doPop;

    // Status flags and effective push/pop qualification
    always_comb begin
        full       = (count == CntW'(Depth));
        almostFull = (count == CntW'(Depth - 1));
        empty      = (count == '0);
        doPop      = pop & ~empty;
        doPush     = push & (~full | doPop);
        popLen     = lenMem[rdPtr];
        popLast    = lastMem[rdPtr];
    end

    // Entry storage, no reset needed as occupancy gates every read
    always_ff @(posedge clk) begin
        if (doPush) begin
            lenMem[wrPtr]  <= pushLen;
            lastMem[wrPtr] <= pushLast;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (srst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (!doPush && doPop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/smi_write_burst_ctrl.sv
// SMI write burst controller: turns byte-addressed write frames into AXI AW bursts
// (split at MaxBurstLen and 4KB), programs the byte aligner offset and gates the
// aligner output onto W with a per-burst WLAST.
// Optional frame checking is enabled with `define SMI_WRITE_BURST_CTRL_CHECK_EN.
module smi_write_burst_ctrl
    import smi_write_burst_ctrl_pkg::*;
#(
    parameter int unsigned FlitWidth   = 16,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned MaxBurstLen = 16,
    parameter int unsigned LenFifoSize = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   reqReady,
    input  logic [AddrWidth-1:0]   reqAddr,
    input  logic [15:0]            reqLength,
    output logic                   reqStop,
    output logic                   setupReady,
    output logic [7:0]             setupOffset,
    input  logic                   setupStop,
    output logic                   axiAwValid,
    output logic [AddrWidth-1:0]   axiAwAddr,
    output logic [AxiLenWidth-1:0] axiAwLen,
    input  logic                   axiAwReady,
    input  logic                   alignedInReady,
    input  logic                   alignedInLast,
    output logic                   alignedInStop,
    output logic                   axiWValid,
    output logic                   axiWLast,
    input  logic                   axiWReady,
    output logic                   protoError
);

    localparam int unsigned OffW = $clog2(FlitWidth);

    burstState_t          state;
    logic [AddrWidth-1:0] addr;
    logic [16:0]          remaining;
    logic                 awLastOfFrame;
    logic [7:0]           beatCnt;

    logic [16:0]          beatsReq;
    logic [16:0]          burstCur;
    logic [AddrWidth-1:0] addrNext;
    logic [16:0]          remNext;
    logic [16:0]          burstNext;
    logic                 awFire;
    logic                 wFire;
    logic                 wPop;

    logic                 fifoFull;
    logic                 fifoAlmostFull;
    logic                 fifoEmpty;
    logic [7:0]           headLen;
    logic                 headLast;

    // Burst sizing for the current and the following AW
    always_comb begin
        beatsReq  = ({1'b0, reqLength} + {{(17 - OffW){1'b0}}, reqAddr[OffW-1:0]}
                     + 17'(FlitWidth - 1)) >> OffW;
        burstCur  = calcBurst(addr[11:0], remaining, MaxBurstLen, OffW);
        addrNext  = addr + (AddrWidth'(burstCur) << OffW);
        remNext   = remaining - burstCur;
        burstNext = calcBurst(addrNext[11:0], remNext, MaxBurstLen, OffW);
        awFire    = axiAwValid & axiAwReady;
    end

    // W handshake gating: beats flow only once their burst entry is queued
    always_comb begin
        axiWValid     = alignedInReady & ~fifoEmpty;
        alignedInStop = ~(axiWReady & ~fifoEmpty);
        axiWLast      = ~fifoEmpty & (beatCnt == headLen);
        wFire         = axiWValid & axiWReady;
        wPop          = wFire & axiWLast;
    end

    // Request/setup/AW sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            state         <= StReset;
            reqStop       <= 1'b1;
            setupReady    <= 1'b0;
            setupOffset   <= '0;
            axiAwValid    <= 1'b0;
            axiAwAddr     <= '0;
            axiAwLen      <= '0;
            awLastOfFrame <= 1'b0;
            addr          <= '0;
            remaining     <= '0;
        end else begin
            unique case (state)
                StReset: begin
                    state   <= StIdle;
                    reqStop <= 1'b0;
                end
                StIdle: begin
                    // Zero-length frames are consumed without setup or AW
                    if (reqReady && !reqStop && reqLength != 16'd0) begin
                        reqStop     <= 1'b1;
                        setupReady  <= 1'b1;
                        setupOffset <= {{(8 - OffW){1'b0}}, reqAddr[OffW-1:0]};
                        addr        <= reqAddr & ~AddrWidth'(FlitWidth - 1);
                        remaining   <= beatsReq;
                        state       <= StSetup;
                    end
                end
                StSetup: begin
                    if (!setupStop) begin
                        setupReady    <= 1'b0;
                        axiAwAddr     <= addr;
                        axiAwLen      <= 8'(burstCur - 17'd1);
                        awLastOfFrame <= (burstCur == remaining);
                        axiAwValid    <= ~(fifoFull & ~wPop);
                        state         <= StAddr;
                    end
                end
                StAddr: begin
                    if (awFire) begin
                        addr      <= addrNext;
                        remaining <= remNext;
                        if (remNext == 17'd0) begin
                            axiAwValid <= 1'b0;
                            reqStop    <= 1'b0;
                            state      <= StIdle;
                        end else begin
                            axiAwAddr     <= addrNext;
                            axiAwLen      <= 8'(burstNext - 17'd1);
                            awLastOfFrame <= (burstNext == remNext);
                            // This push may fill the FIFO, in which case wait for a pop
                            axiAwValid    <= ~(fifoAlmostFull & ~wPop);
                        end
                    end else if (!axiAwValid) begin
                        axiAwValid <= ~(fifoFull & ~wPop);
                    end
                end
                default: state <= StReset;
            endcase
        end
    end

    // Beat position within the head burst
    always_ff @(posedge clk) begin
        if (srst) begin
            beatCnt <= '0;
        end else if (wFire) begin
            beatCnt <= axiWLast ? 8'd0 : beatCnt + 8'd1;
        end
    end

    smi_burst_len_fifo #(
        .Depth(LenFifoSize)
    ) u_lenFifo (
        .clk       (clk),
        .srst      (srst),
        .push      (awFire),
        .pushLen   (axiAwLen),
        .pushLast  (awLastOfFrame),
        .pop       (wPop),
        .popLen    (headLen),
        .popLast   (headLast),
        .full      (fifoFull),
        .almostFull(fifoAlmostFull),
        .empty     (fifoEmpty)
    );

`ifdef SMI_WRITE_BURST_CTRL_CHECK_EN
    // Sticky error when the aligner's frame end disagrees with the burst bookkeeping
    always_ff @(posedge clk) begin
        if (srst) begin
            protoError <= 1'b0;
        end else if (wFire && (alignedInLast != (axiWLast & headLast))) begin
            protoError <= 1'b1;
        end
    end
`else
    logic unusedCheckSigs;
    assign unusedCheckSigs = alignedInLast ^ headLast;
    assign protoError      = 1'b0;
`endif

endmodule
